// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the
// WB stage and a long-latency unit, buffering LU results in a FIFO.
module wb_port_arbiter #(
  parameter int N            = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pipe_valid,
  input  logic         pipe_we,
  input  logic [4:0]   pipe_rd,
  input  logic [N-1:0] pipe_wd,
  output logic         stall_wb,
  input  logic         lu_valid,
  input  logic [4:0]   lu_rd,
  input  logic [N-1:0] lu_wd,
  output logic         lu_ready,
  output logic         rf_we,
  output logic [4:0]   rf_rd,
  output logic [N-1:0] rf_wd,
  output logic [31:0]  pend_mask
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  logic [4:0]    mem_rd [DEPTH];
  logic [N-1:0]  mem_wd [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  logic pipe_req;
  logic fifo_req;
  logic full;
  logic room;
  logic starved;
  logic grant_fifo;
  logic grant_pipe;
  logic push;
  logic pop;

  // request and grant decode, all from registered FIFO state
  always_comb begin
    pipe_req   = pipe_valid & pipe_we & (pipe_rd != 5'd0);
    fifo_req   = (count != '0);
    full       = (count == FULL);
    room       = (count < FULL);
    starved    = (starve_cnt == SLIM);
    grant_fifo = fifo_req & (~pipe_req | full | starved);
    grant_pipe = pipe_req & ~grant_fifo;
    push       = lu_valid & room & (lu_rd != 5'd0);
    pop        = grant_fifo;
  end

  // handshake outputs are forced quiet while reset is held
  always_comb begin
    lu_ready = rst_n & room;
    stall_wb = rst_n & grant_fifo & pipe_req;
  end

  // write-port mux: FIFO head, pipeline result, or idle zeros
  always_comb begin
    rf_we = 1'b0;
    rf_rd = '0;
    rf_wd = '0;
    if (rst_n) begin
      unique case (1'b1)
        grant_fifo: begin
          rf_we = 1'b1;
          rf_rd = mem_rd[rptr];
          rf_wd = mem_wd[rptr];
        end
        grant_pipe: begin
          rf_we = 1'b1;
          rf_rd = pipe_rd;
          rf_wd = pipe_wd;
        end
        default: begin
          rf_we = 1'b0;
        end
      endcase
    end
  end

  // pending destinations of every live FIFO entry
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + PW'(i);
      if (CW'(i) < count) begin
        pend_mask[mem_rd[idx]] = 1'b1;
      end
    end
  end

  // FIFO storage, written at the tail on an accepted LU result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_rd[i] <= '0;
        mem_wd[i] <= '0;
      end
    end else if (push) begin
      mem_rd[wptr] <= lu_rd;
      mem_wd[wptr] <= lu_wd;
    end
  end

  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
    end
  end

  // occupancy tracks push/pop; both at once leaves it unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // counts pipeline wins over a waiting FIFO, saturating at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant_fifo || !fifo_req) begin
      starve_cnt <= '0;
    end else if (grant_pipe && !starved) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule
